// File: rtl/ws2812_frame_streamer_pkg.sv
// Shared constants and types for the WS2812 frame streamer.
// Timing defaults assume a 50 MHz clock.
package ws2812_frame_streamer_pkg;

   localparam int CLK_HZ        = 50_000_000;
   localparam int BIT_CYC_DEF   = 63;     // 1.26 us
   localparam int T0H_CYC_DEF   = 20;
   localparam int T1H_CYC_DEF   = 40;
   localparam int LATCH_CYC_DEF = 15000;  // 300 us
   localparam int BYTES_PER_LED = 3;
   localparam int RAM_TOP       = 8191;

   typedef enum logic [1:0] {IDLE, PRIME, SEND, LATCH} state_t;

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ws2812_frame_streamer_if.sv
// Frame RAM read port (port 2) as seen by the streamer.
interface ws2812_frame_streamer_if #(
   parameter int ADDR_W = 13
);
   logic [ADDR_W-1:0] mem_address;
   logic              mem_chipselect;
   logic              mem_clken;
   logic              mem_write;
   logic [7:0]        mem_readdata;

   modport master (
      output mem_address, mem_chipselect, mem_clken, mem_write,
      input  mem_readdata
   );

   modport slave (
      input  mem_address, mem_chipselect, mem_clken, mem_write,
      output mem_readdata
   );
endinterface

// File: rtl/ws2812_frame_streamer_bit_encoder.sv
// One WS2812 bit cell: high for T0H/T1H cycles, then low until BIT_CYC.
// A bit_start on the bit_end cycle chains the next bit with no gap.
module ws2812_bit_encoder
   import ws2812_frame_streamer_pkg::*;
#(
   parameter int BIT_CYC = BIT_CYC_DEF,
   parameter int T0H_CYC = T0H_CYC_DEF,
   parameter int T1H_CYC = T1H_CYC_DEF,
   parameter int PH_W    = cnt_w(BIT_CYC)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            bit_start,
   input  logic            bit_val,
   output logic            dout,
   output logic            bit_end,
   output logic [PH_W-1:0] phase_cnt
);

   logic          active;
   logic          bit_q;
   logic [PH_W:0] phase_nx;
   logic [PH_W:0] high_cyc;

   assign high_cyc = bit_q ? (PH_W+1)'(T1H_CYC) : (PH_W+1)'(T0H_CYC);
   assign phase_nx = {1'b0, phase_cnt} + (PH_W+1)'(1);
   assign bit_end  = active && (phase_cnt == PH_W'(BIT_CYC - 1));

   // dout is registered so the LED line never sees compare glitches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active    <= 1'b0;
         bit_q     <= 1'b0;
         phase_cnt <= '0;
         dout      <= 1'b0;
      end else if (bit_start) begin
         active    <= 1'b1;
         bit_q     <= bit_val;
         phase_cnt <= '0;
         dout      <= 1'b1;
      end else if (bit_end || !active) begin
         active    <= 1'b0;
         phase_cnt <= '0;
         dout      <= 1'b0;
      end else begin
         phase_cnt <= phase_nx[PH_W-1:0];
         dout      <= (phase_nx < high_cyc);
      end
   end

endmodule

// File: rtl/ws2812_frame_streamer.sv
// Streams NUM_LEDS x GRB bytes from frame RAM port 2 onto a WS2812 line,
// then holds the line low for the latch interval.
module ws2812_frame_streamer
   import ws2812_frame_streamer_pkg::*;
#(
   parameter int NUM_LEDS  = 60,
   parameter int BASE_ADDR = 0,
   parameter int ADDR_W    = 13,
   parameter int BIT_CYC   = BIT_CYC_DEF,
   parameter int T0H_CYC   = T0H_CYC_DEF,
   parameter int T1H_CYC   = T1H_CYC_DEF,
   parameter int LATCH_CYC = LATCH_CYC_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   ws2812_frame_streamer_if.master  mem,
   output logic                     led_dout
);

   localparam int NUM_BYTES = BYTES_PER_LED * NUM_LEDS;
   localparam int PH_W      = cnt_w(BIT_CYC);
   localparam int BC_W      = cnt_w(NUM_BYTES);
   localparam int LC_W      = cnt_w(LATCH_CYC);
   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + NUM_BYTES - 1);

   if (NUM_LEDS < 1) begin : g_err_leds
      $error("NUM_LEDS must be at least 1");
   end
   if (BASE_ADDR + NUM_BYTES - 1 > RAM_TOP || BASE_ADDR + NUM_BYTES > (1 << ADDR_W))
   begin : g_err_addr
      $error("frame does not fit in the frame RAM");
   end
   if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : g_err_tim
      $error("bit timing requires 0 < T0H_CYC < T1H_CYC < BIT_CYC");
   end

   state_t            state, state_nx;
   logic              prime_wait;
   logic [7:0]        shift_reg;
   logic [7:0]        next_byte;
   logic [2:0]        bit_cnt;
   logic [BC_W-1:0]   byte_cnt;
   logic [LC_W-1:0]   latch_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              cs_q;

   logic              bit_start, bit_val, bit_end;
   logic [PH_W-1:0]   phase_cnt;
   logic              last_bit, last_byte, latch_last;

   assign last_bit   = (bit_cnt == 3'd7);
   assign last_byte  = (byte_cnt == BC_W'(NUM_BYTES - 1));
   assign latch_last = (latch_cnt == LC_W'(LATCH_CYC - 1));

   assign mem.mem_address    = addr_q;
   assign mem.mem_chipselect = cs_q;
   assign mem.mem_clken      = 1'b1;
   assign mem.mem_write      = 1'b0;
   assign busy               = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      bit_start = 1'b0;
      bit_val   = shift_reg[6];
      done      = 1'b0;
      case (state)
         IDLE:  if (start) state_nx = PRIME;
         PRIME: if (prime_wait) begin
            bit_start = 1'b1;
            bit_val   = mem.mem_readdata[7];
            state_nx  = SEND;
         end
         SEND:  if (bit_end) begin
            if (!last_bit) begin
               bit_start = 1'b1;
            end else if (!last_byte) begin
               bit_start = 1'b1;
               bit_val   = next_byte[7];
            end else begin
               state_nx  = LATCH;
            end
         end
         LATCH: if (latch_last) begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Address runs one byte ahead of shift_reg; next_byte catches it at
   // phase 1 of bit 0, once the RAM's one-cycle read latency has passed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prime_wait <= 1'b0;
         shift_reg  <= '0;
         next_byte  <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         latch_cnt  <= '0;
         addr_q     <= FIRST_ADDR;
         cs_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               addr_q     <= FIRST_ADDR;
               cs_q       <= 1'b1;
               prime_wait <= 1'b0;
            end
            PRIME: begin
               prime_wait <= ~prime_wait;
               if (prime_wait) begin
                  shift_reg <= mem.mem_readdata;
                  byte_cnt  <= '0;
                  bit_cnt   <= '0;
                  if (addr_q != LAST_ADDR) addr_q <= addr_q + ADDR_W'(1);
               end
            end
            SEND: begin
               if (bit_cnt == 3'd0 && phase_cnt == PH_W'(1)) next_byte <= mem.mem_readdata;
               if (bit_end) begin
                  if (!last_bit) begin
                     shift_reg <= {shift_reg[6:0], 1'b0};
                     bit_cnt   <= bit_cnt + 3'd1;
                  end else if (!last_byte) begin
                     shift_reg <= next_byte;
                     byte_cnt  <= byte_cnt + BC_W'(1);
                     bit_cnt   <= '0;
                     if (addr_q != LAST_ADDR) addr_q <= addr_q + ADDR_W'(1);
                  end else begin
                     cs_q      <= 1'b0;
                     latch_cnt <= '0;
                  end
               end
            end
            LATCH: latch_cnt <= latch_last ? '0 : latch_cnt + LC_W'(1);
            default: ;
         endcase
      end
   end

   ws2812_bit_encoder #(
      .BIT_CYC (BIT_CYC),
      .T0H_CYC (T0H_CYC),
      .T1H_CYC (T1H_CYC),
      .PH_W    (PH_W)
   ) u_enc (
      .clk       (clk),
      .reset     (reset),
      .bit_start (bit_start),
      .bit_val   (bit_val),
      .dout      (led_dout),
      .bit_end   (bit_end),
      .phase_cnt (phase_cnt)
   );

endmodule

// File: tb/tb_ws2812_frame_streamer.sv
// Randomised scoreboard bench: decodes the LED line back into bytes and
// compares bytes, frame timing and handshake against a frame-level model.
module tb_ws2812_frame_streamer;

   localparam int NL   = 14;
   localparam int NB   = 3 * NL;
   localparam int BASE = 8191 - (NB - 1);
   localparam int LAST = BASE + NB - 1;
   localparam int BITC = 10;
   localparam int T0   = 3;
   localparam int T1   = 7;
   localparam int LAT  = 40;
   localparam int DONE_OFS = 3 + NB * 8 * BITC + LAT - 1;  // start cycle -> done cycle
   localparam int RISE_OFS = 3;                            // start cycle -> first high cycle

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic busy, done, led_dout;
   logic [7:0] ram [0:8191];
   logic [7:0] rd_q = 8'h00;
   int cyc = 0;

   ws2812_frame_streamer_if #(.ADDR_W(13)) mem_bus ();

   ws2812_frame_streamer #(
      .NUM_LEDS (NL), .BASE_ADDR (BASE), .ADDR_W (13),
      .BIT_CYC (BITC), .T0H_CYC (T0), .T1H_CYC (T1), .LATCH_CYC (LAT)
   ) dut (
      .clk (clk), .reset (reset), .start (start), .busy (busy), .done (done),
      .mem (mem_bus), .led_dout (led_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame RAM port 2: address registered on the edge, data valid the next cycle.
   always @(posedge clk) if (mem_bus.mem_clken) rd_q <= ram[mem_bus.mem_address];
   assign mem_bus.mem_readdata = rd_q;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] byte_q[$];
   int rise_q[$];
   int done_q[$];
   int last_done = 0;
   int bs = 1, be = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Frame-level model: a start accepted while idle yields NB bytes from BASE,
   // the first high cycle RISE_OFS later and done DONE_OFS later.
   task automatic drive_start(input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         start = 1'b1;
         if (cyc > last_done) begin
            rise_q.push_back(cyc + RISE_OFS);
            for (int i = 0; i < NB; i++) byte_q.push_back(ram[BASE + i]);
            done_q.push_back(cyc + DONE_OFS);
            bs = cyc + 1;
            last_done = cyc + DONE_OFS;
            be = last_done;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic fill_ram();
      for (int i = 0; i < 8192; i++) ram[i] = 8'($urandom);
   endtask

   initial begin : monitor
      int last_rise, w, max_addr, nb;
      bit lr_ok, prev_led, b;
      logic [7:0] sh;
      last_rise = 0; lr_ok = 0; prev_led = 0; nb = 0; sh = 0; max_addr = 0;
      forever begin
         @(negedge clk);
         check("busy", busy, (cyc >= bs && cyc <= be));
         if (reset) begin
            lr_ok = 0; prev_led = 0; nb = 0; max_addr = 0;
         end else begin
            if (led_dout && !prev_led) begin
               if (lr_ok && (cyc - last_rise) < BITC + LAT) begin
                  check("bit_period", cyc - last_rise, BITC);
               end else begin
                  if (lr_ok) check("latch_gap_ok", (cyc - last_rise - BITC) >= LAT, 1);
                  check("frame_pending", rise_q.size() != 0, 1);
                  if (rise_q.size() != 0) check("first_rise_cycle", cyc, rise_q.pop_front());
               end
               last_rise = cyc;
               lr_ok = 1;
            end
            if (!led_dout && prev_led) begin
               w = cyc - last_rise;
               check("high_width_valid", (w == T0 || w == T1), 1);
               b = (w == T1);
               sh = {sh[6:0], b};
               nb++;
               if (nb == 8) begin
                  nb = 0;
                  check("byte_pending", byte_q.size() != 0, 1);
                  if (byte_q.size() != 0) check("byte", sh, byte_q.pop_front());
               end
            end
            if (mem_bus.mem_chipselect) begin
               check("addr_range", (mem_bus.mem_address >= BASE && mem_bus.mem_address <= LAST), 1);
               if (int'(mem_bus.mem_address) > max_addr) max_addr = int'(mem_bus.mem_address);
            end
            if (done) begin
               check("done_pending", done_q.size() != 0, 1);
               if (done_q.size() != 0) check("done_cycle", cyc, done_q.pop_front());
               check("addr_max", max_addr, LAST);
               max_addr = 0;
            end
            prev_led = led_dout;
         end
      end
   end

   initial begin : stim
      int n, gap;
      fill_ram();
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_led", led_dout, 0);
      check("rst_cs", mem_bus.mem_chipselect, 0);
      check("rst_addr", mem_bus.mem_address, BASE);
      check("rst_clken", mem_bus.mem_clken, 1);
      check("rst_write", mem_bus.mem_write, 0);

      // Known pattern, spurious starts mid-SEND, start in the done cycle held
      // one more cycle so it becomes a back-to-back second frame.
      ram[BASE] = 8'hA5; ram[BASE + 1] = 8'h00; ram[BASE + 2] = 8'hFF;
      repeat (2) @(negedge clk);
      n = cyc;
      drive_start(1);
      wait_until(n + 500);
      drive_start(1);
      wait_until(n + 1777);
      drive_start(2);
      wait_until(last_done);
      drive_start(2);
      wait_until(last_done + 5);

      // Reset during byte 37, then a full restart.
      fill_ram();
      n = cyc;
      drive_start(1);
      wait_until(n + RISE_OFS + 37 * 8 * BITC + 35);
      #2 reset = 1'b1;
      #1;
      check("abort_led", led_dout, 0);
      check("abort_busy", busy, 0);
      check("abort_cs", mem_bus.mem_chipselect, 0);
      check("abort_addr", mem_bus.mem_address, BASE);
      byte_q.delete(); rise_q.delete(); done_q.delete();
      bs = 1; be = 0; last_done = cyc;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      drive_start(1);
      wait_until(last_done + 3);

      // Random frames with random idle gaps and ignored starts.
      for (int f = 0; f < 3; f++) begin
         fill_ram();
         gap = int'($urandom_range(1, 20));
         repeat (gap) @(negedge clk);
         n = cyc;
         drive_start(1);
         wait_until(n + int'($urandom_range(5, DONE_OFS / 2)));
         drive_start(1);
         wait_until(n + int'($urandom_range(DONE_OFS / 2 + 1, DONE_OFS - 2)));
         drive_start(1);
         wait_until(last_done + int'($urandom_range(1, 8)));
      end

      for (int k = 0; k < 20000 && (done_q.size() != 0 || byte_q.size() != 0); k++)
         @(negedge clk);
      check("drain_done", done_q.size(), 0);
      check("drain_bytes", byte_q.size(), 0);
      check("drain_rises", rise_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
